product_accumulator: RTL and testbench

- Downstream consumer of the dual-path multiplier stage: takes a stream of WL-bit products and sums each frame of FRAME consecutive products into a WA-bit saturating total.
- Each completed frame total is presented on a valid/ready output port.
- Carries its own formal properties so it can serve as a standalone benchmark or be composed after the multiplier in a larger proof.

---
 rtl/product_accumulator.sv | 147 ++++++++++++++
 tb/tb_product_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Frame accumulator: sums FRAME products into a saturating WA-bit total.
// Define PRODUCT_ACC_ASSERT_EN to add the shadow accumulator and assertions.
module product_accumulator #(
    parameter int WL    = 32,
    parameter int WA    = 40,
    parameter int FRAME = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [WL-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [WA-1:0] out_data,
    output logic          out_ovf,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
    localparam logic [WA-1:0] SAT_MAX = {WA{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [WA-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic [WA-1:0] out_data_q, out_data_d;
    logic          out_ovf_q, out_ovf_d;

    logic          accept;
    logic          last;
    logic [WA:0]   sum;
    logic          add_ovf;
    logic [WA-1:0] sat_sum;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q != IDLE);

    assign accept  = in_valid && in_ready;
    assign last    = (cnt_q == LAST_CNT);
    assign sum     = {1'b0, acc_q} + {{(WA + 1 - WL){1'b0}}, in_data};
    assign add_ovf = sum[WA];
    assign sat_sum = add_ovf ? SAT_MAX : sum[WA-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sat_sum;
                    ovf_d = ovf_q | add_ovf;
                    if (last) begin
                        out_data_d  = sat_sum;
                        out_ovf_d   = ovf_q | add_ovf;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

`ifdef PRODUCT_ACC_ASSERT_EN
    // Exact, non-saturating reference sum for the current frame.
    localparam int WS = WA + 8;
    localparam logic [WS-1:0] SH_MAX = {8'd0, SAT_MAX};

    logic [WS-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (state_q == HOLD && out_ready) begin
            shadow_q <= '0;
        end else if (accept) begin
            shadow_q <= shadow_q + {{(WS - WL){1'b0}}, in_data};
        end
    end

    a_acc_sat: assert property (@(posedge clk) disable iff (rst)
        acc_q == ((shadow_q > SH_MAX) ? SAT_MAX : shadow_q[WA-1:0]));

    a_ovf: assert property (@(posedge clk) disable iff (rst)
        ovf_q == (shadow_q > SH_MAX));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(out_data) && $stable(out_ovf)));

    a_cnt: assert property (@(posedge clk) disable iff (rst)
        int'(cnt_q) < FRAME);

    a_ready: assert property (@(posedge clk) disable iff (rst)
        in_ready == !out_valid);
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator across three parameter sets.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance a: defaults (WL=32, WA=40, FRAME=4)
    logic        a_in_valid = 1'b0;
    logic [31:0] a_in_data  = '0;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [39:0] a_out_data;
    logic        a_out_ovf;
    logic        a_out_ready = 1'b0;
    logic        a_busy;

    // Instance b: WA=34, FRAME=5
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data  = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [33:0] b_out_data;
    logic        b_out_ovf;
    logic        b_out_ready = 1'b1;
    logic        b_busy;

    // Instance c: FRAME=1
    logic        c_in_valid = 1'b0;
    logic [31:0] c_in_data  = '0;
    logic        c_in_ready;
    logic        c_out_valid;
    logic [39:0] c_out_data;
    logic        c_out_ovf;
    logic        c_out_ready = 1'b1;
    logic        c_busy;

    product_accumulator u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ovf(a_out_ovf),
        .out_ready(a_out_ready), .busy(a_busy)
    );

    product_accumulator #(.WL(32), .WA(34), .FRAME(5)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ovf(b_out_ovf),
        .out_ready(b_out_ready), .busy(b_busy)
    );

    product_accumulator #(.WL(32), .WA(40), .FRAME(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_ovf(c_out_ovf),
        .out_ready(c_out_ready), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a falling edge; presents one beat for one cycle.
    task automatic drive_a(input logic [31:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] d);
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_ovf", 64'(a_out_ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back frame 1,2,3,4
        a_out_ready = 1'b1;
        drive_a(32'd1);
        drive_a(32'd2);
        drive_a(32'd3);
        check("b2b_busy_pre", 64'(a_busy), 64'd1);
        check("b2b_valid_pre", 64'(a_out_valid), 64'd0);
        drive_a(32'd4);
        check("b2b_valid", 64'(a_out_valid), 64'd1);
        check("b2b_data", 64'(a_out_data), 64'd10);
        check("b2b_ovf", 64'(a_out_ovf), 64'd0);
        check("b2b_in_ready", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        check("b2b_valid_drop", 64'(a_out_valid), 64'd0);
        check("b2b_in_ready_back", 64'(a_in_ready), 64'd1);
        check("b2b_busy_post", 64'(a_busy), 64'd0);

        // Gapped frame 5,7,9,11 with back-pressure
        a_out_ready = 1'b0;
        drive_a(32'd5);
        idle(2);
        drive_a(32'd7);
        idle(2);
        drive_a(32'd9);
        idle(2);
        drive_a(32'd11);
        a_in_valid = 1'b1;
        a_in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(a_out_valid), 64'd1);
            check("hold_data", 64'(a_out_data), 64'd32);
            check("hold_in_ready", 64'(a_in_ready), 64'd0);
            @(negedge clk);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("hold_release", 64'(a_out_valid), 64'd0);
        check("hold_busy_post", 64'(a_busy), 64'd0);

        // Abort a partial frame with an asynchronous reset
        drive_a(32'd6);
        drive_a(32'd6);
        check("abort_busy_pre", 64'(a_busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_in_ready", 64'(a_in_ready), 64'd1);
        check("abort_valid", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_a(32'd1);
        drive_a(32'd1);
        drive_a(32'd1);
        check("abort_no_out", 64'(a_out_valid), 64'd0);
        drive_a(32'd1);
        check("abort_valid_new", 64'(a_out_valid), 64'd1);
        check("abort_data_new", 64'(a_out_data), 64'd4);
        @(negedge clk);

        // Saturation: WA=34, FRAME=5
        for (int i = 0; i < 5; i++) drive_b(32'hFFFF_FFFF);
        check("sat_valid", 64'(b_out_valid), 64'd1);
        check("sat_data", 64'(b_out_data), 64'h3_FFFF_FFFF);
        check("sat_ovf", 64'(b_out_ovf), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) drive_b(32'd1);
        check("post_sat_valid", 64'(b_out_valid), 64'd1);
        check("post_sat_data", 64'(b_out_data), 64'd5);
        check("post_sat_ovf", 64'(b_out_ovf), 64'd0);
        @(negedge clk);

        // FRAME=1: each beat is a frame; second beat waits one bubble
        c_in_valid = 1'b1;
        c_in_data  = 32'd3;
        @(negedge clk);
        check("f1_valid_a", 64'(c_out_valid), 64'd1);
        check("f1_data_a", 64'(c_out_data), 64'd3);
        check("f1_in_ready_a", 64'(c_in_ready), 64'd0);
        c_in_data = 32'd4;
        @(negedge clk);
        check("f1_bubble_valid", 64'(c_out_valid), 64'd0);
        check("f1_bubble_ready", 64'(c_in_ready), 64'd1);
        @(negedge clk);
        c_in_valid = 1'b0;
        check("f1_valid_b", 64'(c_out_valid), 64'd1);
        check("f1_data_b", 64'(c_out_data), 64'd4);
        check("f1_ovf_b", 64'(c_out_ovf), 64'd0);
        @(negedge clk);
        check("f1_idle", 64'(c_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
